id_pair_receiver: RTL and testbench

ID_PAIR_RECEIVER -- requirements
Module: id_pair_receiver

---
 rtl/id_pair_receiver_pkg.sv | 20 ++
 rtl/id_pair_receiver_lane_match.sv | 15 +
 rtl/id_pair_receiver.sv | 131 +++++++++++++
 tb/tb_id_pair_receiver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/id_pair_receiver_pkg.sv
// Shared constants for the paired-lane decode receiver: FSM encoding, PC geometry
// and the accept-clamping rule used by dispatch handshaking.
package id_pair_receiver_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Dispatch may request 3; it can never take more than two slots.
    function automatic logic [1:0] clamp_accept(input logic [1:0] req,
                                                input logic [1:0] avail);
        logic [1:0] lim;
        lim = (req == 2'd3) ? 2'd2 : req;
        return (lim < avail) ? lim : avail;
    endfunction

endpackage

// File: rtl/id_pair_receiver_lane_match.sv
// Per-lane pending detect: a fetched slot counts only when its order bit is the
// one this lane expects next and the receiver is running.
module lane_match
    import id_pair_receiver_pkg::*;
(
    input  logic       valid,
    input  logic       order,
    input  logic       exp_order,
    input  logic [1:0] state,
    output logic       pending
);

    assign pending = valid & (order == exp_order) & (state == ST_RUN);

endmodule

// File: rtl/id_pair_receiver.sv
// Two-lane decode receiver: presents the oldest two pending fetch slots in age
// order, tracks per-lane order bits and counts instructions taken by dispatch.
module id_pair_receiver
    import id_pair_receiver_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] r_id1_pc_Q,
    input  logic            r_id1_valid_Q,
    input  logic            r_id1_order_Q,
    input  logic [PC_W-1:0] r_id2_pc_Q,
    input  logic            r_id2_valid_Q,
    input  logic            r_id2_order_Q,
    input  logic            s_if_jump_Q,
    input  logic [1:0]      ex_accept,
    output logic [PC_W-1:0] id_slot0_pc,
    output logic            id_slot0_valid,
    output logic [PC_W-1:0] id_slot1_pc,
    output logic            id_slot1_valid,
    output logic            s_id1_stall_D,
    output logic            s_id2_stall_D,
    output logic [31:0]     issue_cnt,
    output logic [1:0]      state
);

    logic [1:0]  state_q, state_d;
    logic        exp1_q, exp1_d;
    logic        exp2_q, exp2_d;
    logic        head_q, head_d;
    logic [31:0] issue_cnt_q, issue_cnt_d;

    logic            pend1, pend2;
    logic            head_pend, oth_pend;
    logic [PC_W-1:0] head_pc, oth_pc;
    logic            kill;
    logic            slot0_v, slot1_v;
    logic [1:0]      n_take;
    logic            take_head, take_oth;
    logic            take1, take2;

    lane_match u_lane1 (
        .valid     (r_id1_valid_Q),
        .order     (r_id1_order_Q),
        .exp_order (exp1_q),
        .state     (state_q),
        .pending   (pend1)
    );

    lane_match u_lane2 (
        .valid     (r_id2_valid_Q),
        .order     (r_id2_order_Q),
        .exp_order (exp2_q),
        .state     (state_q),
        .pending   (pend2)
    );

    // NOTE: every signal gets a default at the top so no path can infer a latch.
    always_comb begin
        head_pend = head_q ? pend2 : pend1;
        oth_pend  = head_q ? pend1 : pend2;
        head_pc   = head_q ? r_id2_pc_Q : r_id1_pc_Q;
        oth_pc    = head_q ? r_id1_pc_Q : r_id2_pc_Q;

        // A redirect or reset this cycle hides everything from dispatch.
        kill    = RST | s_if_jump_Q;
        slot0_v = head_pend & ~kill;
        slot1_v = slot0_v & oth_pend & (oth_pc == head_pc + PC_STEP);

        n_take    = clamp_accept(ex_accept, {1'b0, slot0_v} + {1'b0, slot1_v});
        take_head = (n_take != 2'd0);
        take_oth  = (n_take == 2'd2);
        take1     = head_q ? take_oth  : take_head;
        take2     = head_q ? take_head : take_oth;

        state_d     = state_q;
        exp1_d      = exp1_q;
        exp2_d      = exp2_q;
        head_d      = head_q;
        issue_cnt_d = issue_cnt_q + {30'd0, n_take};

        if (n_take == 2'd1) begin
            if (head_q) exp2_d = ~exp2_q;
            else        exp1_d = ~exp1_q;
            head_d = ~head_q;
        end else if (n_take == 2'd2) begin
            exp1_d = ~exp1_q;
            exp2_d = ~exp2_q;
        end

        if (s_if_jump_Q) begin
            exp1_d = 1'b0;
            exp2_d = 1'b0;
            head_d = 1'b0;
        end

        case (state_q)
            ST_IDLE:  if (r_id1_valid_Q | r_id2_valid_Q) state_d = ST_RUN;
            ST_RUN:   if (s_if_jump_Q) state_d = ST_FLUSH;
            ST_FLUSH: state_d = s_if_jump_Q ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign id_slot0_valid = slot0_v;
    assign id_slot1_valid = slot1_v;
    assign id_slot0_pc    = slot0_v ? head_pc : '0;
    assign id_slot1_pc    = slot1_v ? oth_pc  : '0;
    assign s_id1_stall_D  = pend1 & ~take1 & ~kill;
    assign s_id2_stall_D  = pend2 & ~take2 & ~kill;
    // Registered observables read as zero throughout the reset cycle itself.
    assign issue_cnt      = RST ? 32'd0 : issue_cnt_q;
    assign state          = RST ? ST_IDLE : state_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            exp1_q      <= 1'b0;
            exp2_q      <= 1'b0;
            head_q      <= 1'b0;
            issue_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            exp1_q      <= exp1_d;
            exp2_q      <= exp2_d;
            head_q      <= head_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_pair_receiver.sv
// Self-checking bench for id_pair_receiver: directed vector table, then random
// traffic against a lane-array reference model, including counter wrap.
module tb_id_pair_receiver;

    logic        CLK;
    logic        RST;
    logic [31:0] r_id1_pc_Q, r_id2_pc_Q;
    logic        r_id1_valid_Q, r_id1_order_Q, r_id2_valid_Q, r_id2_order_Q;
    logic        s_if_jump_Q;
    logic [1:0]  ex_accept;
    logic [31:0] id_slot0_pc, id_slot1_pc;
    logic        id_slot0_valid, id_slot1_valid;
    logic        s_id1_stall_D, s_id2_stall_D;
    logic [31:0] issue_cnt;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    id_pair_receiver dut (
        .CLK            (CLK),
        .RST            (RST),
        .r_id1_pc_Q     (r_id1_pc_Q),
        .r_id1_valid_Q  (r_id1_valid_Q),
        .r_id1_order_Q  (r_id1_order_Q),
        .r_id2_pc_Q     (r_id2_pc_Q),
        .r_id2_valid_Q  (r_id2_valid_Q),
        .r_id2_order_Q  (r_id2_order_Q),
        .s_if_jump_Q    (s_if_jump_Q),
        .ex_accept      (ex_accept),
        .id_slot0_pc    (id_slot0_pc),
        .id_slot0_valid (id_slot0_valid),
        .id_slot1_pc    (id_slot1_pc),
        .id_slot1_valid (id_slot1_valid),
        .s_id1_stall_D  (s_id1_stall_D),
        .s_id2_stall_D  (s_id2_stall_D),
        .issue_cnt      (issue_cnt),
        .state          (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit v1, input bit o1, input logic [31:0] pc1,
                         input bit v2, input bit o2, input logic [31:0] pc2,
                         input bit jmp, input logic [1:0] acc);
        RST           = rst;
        r_id1_valid_Q = v1;
        r_id1_order_Q = o1;
        r_id1_pc_Q    = pc1;
        r_id2_valid_Q = v2;
        r_id2_order_Q = o2;
        r_id2_pc_Q    = pc2;
        s_if_jump_Q   = jmp;
        ex_accept     = acc;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; bit v1; bit o1; logic [31:0] pc1; bit v2; bit o2; logic [31:0] pc2;
        bit jmp; logic [1:0] acc;
        bit ev0; logic [31:0] epc0; bit ev1; logic [31:0] epc1;
        bit es1; bit es2; logic [31:0] ecnt; logic [1:0] est;
    } vec_t;

    vec_t vecs[15];

    // ---------------- reference model ----------------
    bit          m_exp[2];
    int          m_head;
    int          m_state;   // 0 idle, 1 run, 2 flush
    logic [31:0] m_cnt;

    task automatic mcycle(input bit rst, input bit v1, input bit o1, input logic [31:0] pc1,
                          input bit v2, input bit o2, input logic [31:0] pc2,
                          input bit jmp, input logic [1:0] acc);
        bit          v[2], o[2], pend[2], taken[2];
        logic [31:0] pc[2];
        int          h, ot, lim, avail, n;
        bit          ev0, ev1;
        drive(rst, v1, o1, pc1, v2, o2, pc2, jmp, acc);
        v[0] = v1; o[0] = o1; pc[0] = pc1;
        v[1] = v2; o[1] = o2; pc[1] = pc2;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) pend[k] = v[k] && (o[k] == m_exp[k]) && (m_state == 1);
        h   = m_head;
        ot  = 1 - h;
        ev0 = !rst && !jmp && pend[h];
        ev1 = ev0 && pend[ot] && (pc[ot] == pc[h] + 32'd4);
        lim   = (acc == 2'd3) ? 2 : int'(acc);
        avail = int'(ev0) + int'(ev1);
        n     = (lim < avail) ? lim : avail;
        taken[h]  = (n >= 1);
        taken[ot] = (n == 2);
        check("m_slot0_valid", {31'd0, id_slot0_valid}, {31'd0, ev0});
        check("m_slot1_valid", {31'd0, id_slot1_valid}, {31'd0, ev1});
        if (ev0) check("m_slot0_pc", id_slot0_pc, pc[h]);
        if (ev1) check("m_slot1_pc", id_slot1_pc, pc[ot]);
        check("m_stall1", {31'd0, s_id1_stall_D}, {31'd0, (!rst && !jmp && pend[0] && !taken[0])});
        check("m_stall2", {31'd0, s_id2_stall_D}, {31'd0, (!rst && !jmp && pend[1] && !taken[1])});
        check("m_issue_cnt", issue_cnt, rst ? 32'd0 : m_cnt);
        check("m_state", {30'd0, state}, rst ? 32'd0 : m_state);
        @(posedge CLK);
        if (rst) begin
            m_exp[0] = 0; m_exp[1] = 0; m_head = 0; m_state = 0; m_cnt = 0;
        end else begin
            m_cnt = m_cnt + n;
            if (n == 1) begin
                m_exp[h] = !m_exp[h];
                m_head   = ot;
            end else if (n == 2) begin
                m_exp[0] = !m_exp[0];
                m_exp[1] = !m_exp[1];
            end
            if (jmp) begin
                m_exp[0] = 0; m_exp[1] = 0; m_head = 0;
            end
            case (m_state)
                0: if (v1 || v2) m_state = 1;
                1: if (jmp) m_state = 2;
                default: m_state = jmp ? 2 : 1;
            endcase
        end
        #1;
    endtask

    initial begin
        logic [31:0] base, pc1, pc2;
        int          mode;

        drive(1'b1, 0, 0, 32'd0, 0, 0, 32'd0, 0, 2'd0);
        @(posedge CLK); #1;

        //          rst v1 o1 pc1        v2 o2 pc2        jmp acc  ev0 epc0       ev1 epc1       s1 s2 cnt    st
        vecs[0]  = '{1, 1, 0, 32'h100, 1, 0, 32'h104, 0, 2'd2, 0, 32'h0,   0, 32'h0,   0, 0, 32'd0, 2'd0};
        vecs[1]  = '{0, 1, 0, 32'h100, 1, 0, 32'h104, 0, 2'd2, 0, 32'h0,   0, 32'h0,   0, 0, 32'd0, 2'd0};
        vecs[2]  = '{0, 1, 0, 32'h100, 1, 0, 32'h104, 0, 2'd2, 1, 32'h100, 1, 32'h104, 0, 0, 32'd0, 2'd1};
        vecs[3]  = '{0, 1, 1, 32'h108, 1, 1, 32'h10C, 0, 2'd1, 1, 32'h108, 1, 32'h10C, 0, 1, 32'd2, 2'd1};
        vecs[4]  = '{0, 1, 0, 32'h110, 1, 1, 32'h10C, 0, 2'd0, 1, 32'h10C, 1, 32'h110, 1, 1, 32'd3, 2'd1};
        vecs[5]  = '{0, 1, 0, 32'h118, 1, 1, 32'h10C, 0, 2'd2, 1, 32'h10C, 0, 32'h0,   1, 0, 32'd3, 2'd1};
        vecs[6]  = '{0, 1, 0, 32'h118, 1, 0, 32'h11C, 1, 2'd2, 0, 32'h0,   0, 32'h0,   0, 0, 32'd4, 2'd1};
        vecs[7]  = '{0, 1, 0, 32'h200, 1, 0, 32'h204, 0, 2'd2, 0, 32'h0,   0, 32'h0,   0, 0, 32'd4, 2'd2};
        vecs[8]  = '{0, 1, 0, 32'h200, 1, 0, 32'h204, 0, 2'd0, 1, 32'h200, 1, 32'h204, 1, 1, 32'd4, 2'd1};
        vecs[9]  = '{0, 1, 0, 32'h200, 1, 0, 32'h204, 1, 2'd0, 0, 32'h0,   0, 32'h0,   0, 0, 32'd4, 2'd1};
        vecs[10] = '{0, 1, 0, 32'h200, 1, 0, 32'h204, 1, 2'd0, 0, 32'h0,   0, 32'h0,   0, 0, 32'd4, 2'd2};
        vecs[11] = '{0, 1, 0, 32'h200, 1, 0, 32'h204, 0, 2'd2, 0, 32'h0,   0, 32'h0,   0, 0, 32'd4, 2'd2};
        vecs[12] = '{0, 1, 0, 32'h200, 1, 0, 32'h204, 0, 2'd3, 1, 32'h200, 1, 32'h204, 0, 0, 32'd4, 2'd1};
        vecs[13] = '{1, 1, 1, 32'h208, 1, 1, 32'h20C, 0, 2'd2, 0, 32'h0,   0, 32'h0,   0, 0, 32'd0, 2'd0};
        vecs[14] = '{0, 1, 0, 32'h100, 1, 0, 32'h104, 0, 2'd2, 0, 32'h0,   0, 32'h0,   0, 0, 32'd0, 2'd0};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].v1, vecs[i].o1, vecs[i].pc1,
                  vecs[i].v2, vecs[i].o2, vecs[i].pc2, vecs[i].jmp, vecs[i].acc);
            @(negedge CLK);
            check($sformatf("v%0d_slot0_valid", i), {31'd0, id_slot0_valid}, {31'd0, vecs[i].ev0});
            check($sformatf("v%0d_slot0_pc", i), id_slot0_pc, vecs[i].epc0);
            check($sformatf("v%0d_slot1_valid", i), {31'd0, id_slot1_valid}, {31'd0, vecs[i].ev1});
            check($sformatf("v%0d_slot1_pc", i), id_slot1_pc, vecs[i].epc1);
            check($sformatf("v%0d_stall1", i), {31'd0, s_id1_stall_D}, {31'd0, vecs[i].es1});
            check($sformatf("v%0d_stall2", i), {31'd0, s_id2_stall_D}, {31'd0, vecs[i].es2});
            check($sformatf("v%0d_issue_cnt", i), issue_cnt, vecs[i].ecnt);
            check($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, vecs[i].est});
            @(posedge CLK); #1;
        end

        // Model-driven phase: reset, start running, then preload the counter to force a wrap.
        mcycle(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 2'd0);
        mcycle(0, 1, 0, 32'h300, 1, 0, 32'h304, 0, 2'd0);
        force dut.issue_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.issue_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        mcycle(0, 1, 0, 32'h300, 1, 0, 32'h304, 0, 2'd2);
        check("wrap_issue_cnt", issue_cnt, 32'h0000_0001);

        // Head on lane 2 at the top of the address space: lane 1 at 0x0 still pairs.
        mcycle(0, 1, 1, 32'h308, 1, 1, 32'hFFFF_FFFC, 0, 2'd1);
        mcycle(0, 1, 0, 32'h0,   1, 1, 32'hFFFF_FFFC, 0, 2'd1);
        check("pcwrap_slot0_pc", id_slot0_pc, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            base = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
            mode = $urandom % 3;
            if (mode == 0)      begin pc1 = base; pc2 = base + 32'd4; end
            else if (mode == 1) begin pc2 = base; pc1 = base + 32'd4; end
            else                begin pc1 = base; pc2 = $urandom & 32'h0000_0FFC; end
            mcycle((($urandom % 200) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, pc1,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, pc2,
                   (($urandom % 16) == 0), 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
